// File: rtl/pipe_mux_skid_pkg.sv
// pipe_pkg: handshake state codes ({skid_v, main_v}) and select-width helper
package pipe_pkg;
    localparam logic [1:0] EMPTY = 2'b00;
    localparam logic [1:0] HALF  = 2'b01;
    localparam logic [1:0] FULL  = 2'b11;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/pipe_mux_skid_sel.sv
// pipe_sel_comb: N:1 word selector; out-of-range selects fall back to input 0
module pipe_sel_comb
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N = 4,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic [N*WIDTH-1:0] i_data,
    input  logic [SEL_W-1:0]   i_sel,
    output logic [WIDTH-1:0]   o_word,
    output logic               o_oob
);
    always_comb begin
        o_word = i_data[WIDTH-1:0];
        for (int k = 1; k < N; k++)
            if (int'(i_sel) == k) o_word = i_data[k*WIDTH +: WIDTH];
    end

    assign o_oob = int'(i_sel) >= N;
endmodule

// File: rtl/pipe_mux_skid.sv
// pipe_mux_skid: N-way select into a registered 2-entry skid buffer
// with valid/ready handshake, flush and sticky out-of-range select flag.
module pipe_mux_skid
    import pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N = 4,
    localparam int SEL_W = clog2_min1(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] data_in,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               flush,
    output logic               sel_err,
    input  logic               err_clr
);
    logic [WIDTH-1:0] w_word;
    logic             w_oob;
    logic             r_main_v, r_skid_v, r_in_ready, r_sel_err;
    logic [WIDTH-1:0] r_main_d, r_skid_d;
    logic [1:0]       w_state, w_nxt;
    logic             w_acc, w_pop;

    pipe_sel_comb #(.WIDTH(WIDTH), .N(N)) u_sel (
        .i_data (data_in),
        .i_sel  (sel),
        .o_word (w_word),
        .o_oob  (w_oob)
    );

    assign w_state = {r_skid_v, r_main_v};
    assign w_acc   = in_valid && r_in_ready && !flush;
    assign w_pop   = r_main_v && out_ready && !flush;

    // the unreachable {1,0} code recovers to EMPTY
    assign w_nxt = flush               ? EMPTY :
                   (w_state == EMPTY)  ? (w_acc ? HALF : EMPTY) :
                   (w_state == HALF)   ? ((w_acc && !w_pop) ? FULL : (!w_acc && w_pop) ? EMPTY : HALF) :
                   (w_state == FULL)   ? (w_pop ? HALF : FULL) : EMPTY;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_v   <= 1'b0;
            r_skid_v   <= 1'b0;
            r_in_ready <= 1'b1;
            r_sel_err  <= 1'b0;
            r_main_d   <= '0;
            r_skid_d   <= '0;
        end else begin
            r_main_v   <= w_nxt[0];
            r_skid_v   <= w_nxt[1];
            r_in_ready <= !w_nxt[1];
            if (w_state == FULL && w_pop)
                r_main_d <= r_skid_d;
            else if (w_acc && (w_state == EMPTY || w_pop))
                r_main_d <= w_word;
            if (w_acc && w_state == HALF && !w_pop)
                r_skid_d <= w_word;
            if (w_acc && w_oob)
                r_sel_err <= 1'b1;
            else if (err_clr)
                r_sel_err <= 1'b0;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_data  = r_main_d;
    assign out_valid = r_main_v;
    assign sel_err   = r_sel_err;

    a_no_skid_only: assert property (@(posedge clk) disable iff (!rst_n) !(r_skid_v && !r_main_v));
    a_ready_match:  assert property (@(posedge clk) disable iff (!rst_n) r_in_ready == !r_skid_v);
endmodule
